pipe_stage_skid: RTL and testbench

//  Generic parametrised pipeline-stage register: the successor to the fixed per-stage latches (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 138 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline-stage register with an optional 2-entry skid buffer,
// synchronous flush, debug hold and a saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 110,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_stall;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = w_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // hold needs no explicit term here: it forces both handshakes low, so nothing moves.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer && HAS_SKID) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = ~hold & (r_state != S_EMPTY);
        if (HAS_SKID) begin
            w_in_ready = rst_n & ~hold & (r_state != S_TWO);
        end else begin
            w_in_ready = rst_n & ~hold & ((r_state == S_EMPTY) | out_ready);
        end
        unique case (r_state)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && !flush && (r_stall != '1)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance,
// each with its own expected-payload queue and output monitor.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 110;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;

    logic          a_flush, a_hold, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;
    logic [CW-1:0] a_stall;

    logic          b_flush, b_hold, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;
    logic [CW-1:0] b_stall;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    logic [DW-1:0] a_outs[$];
    logic [DW-1:0] b_outs[$];
    bit            rec;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .hold(a_hold),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .hold(b_hold),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop expected payload whenever a downstream handshake is about to occur.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_out actual=%0h expected=none", a_out_data);
            end else begin
                logic [DW-1:0] e;
                e = q_a.pop_front();
                if (a_out_data !== e) begin
                    failures++;
                    $display("FAIL a_out_data actual=%0h expected=%0h", a_out_data, e);
                end
            end
            if (rec) a_outs.push_back(a_out_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_out actual=%0h expected=none", b_out_data);
            end else begin
                logic [DW-1:0] e;
                e = q_b.pop_front();
                if (b_out_data !== e) begin
                    failures++;
                    $display("FAIL b_out_data actual=%0h expected=%0h", b_out_data, e);
                end
            end
            if (rec) b_outs.push_back(b_out_data);
        end
    end

    // Offer d to instance sel (0=a, 1=b) until accepted; expected payload pushed on acceptance.
    task automatic send(input bit sel, input logic [DW-1:0] d, input bit comb_chk);
        bit acc;
        acc = 1'b0;
        if (sel == 1'b0) begin a_in_valid = 1'b1; a_in_data = d; end
        else             begin b_in_valid = 1'b1; b_in_data = d; end
        for (int c = 0; c < 30 && !acc; c++) begin
            @(negedge clk);
            if (sel == 1'b0) begin
                if (a_in_ready) begin q_a.push_back(d); acc = 1'b1; end
            end else begin
                if (comb_chk) chk("t6_b_in_ready_follows_out_ready", b_in_ready, b_out_ready);
                if (b_in_ready) begin q_b.push_back(d); acc = 1'b1; end
            end
            @(posedge clk); #1;
        end
        chk("send_accepted", acc, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        rec   = 1'b0;
        a_flush = 0; a_hold = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_hold = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_occ", a_occ, 2'd0);
        chk("rst_stall", a_stall, 4'd0);
        chk("rst_out_data", a_out_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: streaming at full rate, one-cycle latency
        a_out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = DW'(i);
            @(negedge clk);
            chk("t1_in_ready", a_in_ready, 1'b1);
            q_a.push_back(DW'(i));
            @(posedge clk); #1;
            chk("t1_occ", a_occ, 2'd1);
            chk("t1_out_valid", a_out_valid, 1'b1);
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_drained_occ", a_occ, 2'd0);
        chk("t1_stall", a_stall, 4'd0);

        // 2: back-pressure fills both entries, then drains in order
        a_out_ready = 1'b0;
        send(1'b0, DW'(16'h10), 1'b0);
        send(1'b0, DW'(16'h11), 1'b0);
        chk("t2_occ_two", a_occ, 2'd2);
        chk("t2_stall_1", a_stall, 4'd1);
        a_in_valid = 1'b1;
        a_in_data  = DW'(16'h12);
        repeat (3) begin
            @(negedge clk);
            chk("t2_in_ready_low", a_in_ready, 1'b0);
            chk("t2_occ_hold", a_occ, 2'd2);
            @(posedge clk); #1;
        end
        chk("t2_stall_4", a_stall, 4'd4);
        a_out_ready = 1'b1;
        send(1'b0, DW'(16'h12), 1'b0);
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_drained", q_a.size(), 0);
        chk("t2_stall_final", a_stall, 4'd4);

        // 3: flush at occupancy 2 with a payload offered
        a_out_ready = 1'b0;
        send(1'b0, DW'(16'h20), 1'b0);
        send(1'b0, DW'(16'h21), 1'b0);
        chk("t3_occ_two", a_occ, 2'd2);
        a_in_valid = 1'b1;
        a_in_data  = DW'(16'h22);
        a_flush    = 1'b1;
        @(posedge clk); #1;
        q_a.delete();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        chk("t3_occ_zero", a_occ, 2'd0);
        chk("t3_out_valid", a_out_valid, 1'b0);
        chk("t3_out_data", a_out_data, '0);
        chk("t3_stall", a_stall, 4'd5);
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 4: hold at occupancy 1 freezes everything
        a_out_ready = 1'b0;
        send(1'b0, DW'(16'h30), 1'b0);
        a_hold     = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = DW'(16'h31);
        repeat (5) begin
            @(negedge clk);
            chk("t4_out_valid", a_out_valid, 1'b0);
            chk("t4_in_ready", a_in_ready, 1'b0);
            chk("t4_occ", a_occ, 2'd1);
            chk("t4_stall", a_stall, 4'd5);
            @(posedge clk); #1;
        end
        a_hold      = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", a_out_valid, 1'b1);
        chk("t4_release_data", a_out_data, DW'(16'h30));
        @(posedge clk); #1;
        chk("t4_stall_after", a_stall, 4'd5);

        // 5: stall counter saturation, survives flush, cleared by reset
        a_out_ready = 1'b0;
        send(1'b0, DW'(16'h40), 1'b0);
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_saturated", a_stall, 4'd15);
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
        q_a.delete();
        chk("t5_after_flush", a_stall, 4'd15);
        chk("t5_flush_occ", a_occ, 2'd0);
        rst_n = 1'b0;
        #2;
        chk("t5_rst_stall", a_stall, 4'd0);
        chk("t5_rst_in_ready", a_in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 6: toggling out_ready on both variants, identical output streams
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        rec = 1'b1;
        fork
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    a_out_ready = ~a_out_ready;
                    b_out_ready = ~b_out_ready;
                end
            end
            begin
                for (int i = 0; i < 8; i++) send(1'b0, DW'(8'h50 + i), 1'b0);
                a_in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) send(1'b1, DW'(8'h50 + i), (i != 0));
                b_in_valid = 1'b0;
            end
        join
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rec = 1'b0;
        chk("t6_a_count", a_outs.size(), 8);
        chk("t6_b_count", b_outs.size(), 8);
        if (a_outs.size() == 8 && b_outs.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t6_streams_equal", a_outs[i], b_outs[i]);
                chk("t6_stream_value", b_outs[i], DW'(8'h50 + i));
            end
        end
        chk("final_q_a_empty", q_a.size(), 0);
        chk("final_q_b_empty", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
